// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled down-counting timer with one-shot/periodic modes and
// a level interrupt on expiry. Register access goes through a single-cycle
// write/read port.
//
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_wr, i_rd         write / read strobes
//   i_addr, i_wdata    register index and write data
//   i_capture          capture input (only with TIMER_CAPTURE_EN)
//   o_rdata            registered read data, held until the next read
//   o_irq              registered level interrupt
//   o_count            live counter value
//
// Register map: 0 CTRL {IRQEN,PERIODIC,EN}, 1 RELOAD, 2 PRESCALE,
//               3 STATUS {CAP,EXP} (W1C), 4 COUNT (RO), 5 CAPTURE (RO).
//
// Optional feature macro: TIMER_CAPTURE_EN adds i_capture, a 2-flop
// synchronizer, the CAPTURE register and the STATUS.CAP flag.
module timer_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr,
  input  logic                  i_rd,
  input  logic [2:0]            i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
`ifdef TIMER_CAPTURE_EN
  input  logic                  i_capture,
`endif
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_irq,
  output logic [DATA_WIDTH-1:0] o_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic                      en_q, en_d;
  logic                      periodic_q, periodic_d;
  logic                      irqen_q, irqen_d;
  logic [DATA_WIDTH-1:0]     reload_q, reload_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      exp_q, exp_d;
  logic [DATA_WIDTH-1:0]     count_q, count_d;
  logic [PRESCALE_WIDTH-1:0] pscnt_q, pscnt_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      irq_q, irq_d;

  logic                      wr_ctrl, wr_reload, wr_prescale, wr_status;
  logic                      expire;
  logic                      cap_flag;
  logic [DATA_WIDTH-1:0]     rd_mux;

`ifdef TIMER_CAPTURE_EN
  logic                  cap_meta_q, cap_sync_q, cap_prev_q;
  logic                  cap_q, cap_d;
  logic [DATA_WIDTH-1:0] capture_q, capture_d;
`endif

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    irqen_d    = irqen_q;
    reload_d   = reload_q;
    prescale_d = prescale_q;
    exp_d      = exp_q;
    count_d    = count_q;
    pscnt_d    = pscnt_q;
    expire     = 1'b0;

    wr_ctrl     = i_wr && (i_addr == 3'd0);
    wr_reload   = i_wr && (i_addr == 3'd1);
    wr_prescale = i_wr && (i_addr == 3'd2);
    wr_status   = i_wr && (i_addr == 3'd3);

    if (wr_ctrl) begin
      en_d       = i_wdata[0];
      periodic_d = i_wdata[1];
      irqen_d    = i_wdata[2];
    end
    if (wr_reload)   reload_d   = i_wdata;
    if (wr_prescale) prescale_d = i_wdata[PRESCALE_WIDTH-1:0];
    if (wr_status && i_wdata[0]) exp_d = 1'b0;

    case (state_q)
      RUN: begin
        if (wr_ctrl && !i_wdata[0]) begin
          state_d = IDLE;                      // count and prescaler freeze
        end else if (pscnt_q == prescale_q) begin
          pscnt_d = '0;
          if (count_q == '0) begin
            expire = 1'b1;
            if (periodic_q) begin
              count_d = reload_q;
            end else begin
              en_d    = 1'b0;                  // one-shot: count stays at 0
              state_d = DONE;
            end
          end else begin
            count_d = count_q - DATA_WIDTH'(1);
          end
        end else begin
          // Free-running increment; wraps if PRESCALE was lowered below it.
          pscnt_d = pscnt_q + PRESCALE_WIDTH'(1);
        end
      end
      default: begin                           // IDLE, DONE: EN is 0 here
        if (wr_ctrl && i_wdata[0]) begin
          state_d = RUN;
          count_d = reload_q;
          pscnt_d = '0;
        end else if (wr_ctrl) begin
          state_d = IDLE;
        end
      end
    endcase

    // Set beats a same-cycle W1C.
    if (expire) exp_d = 1'b1;
  end

`ifdef TIMER_CAPTURE_EN
  always_comb begin
    cap_d     = cap_q;
    capture_d = capture_q;
    if (wr_status && i_wdata[1]) cap_d = 1'b0;
    if (cap_sync_q && !cap_prev_q) begin
      cap_d     = 1'b1;
      capture_d = count_q;
    end
  end
  assign cap_flag = cap_q;
`else
  assign cap_flag = 1'b0;
`endif

  // Read mux sees only registered state, so a same-cycle write reads old data.
  always_comb begin
    rd_mux = '0;
    case (i_addr)
      3'd0: rd_mux[2:0] = {irqen_q, periodic_q, en_q};
      3'd1: rd_mux = reload_q;
      3'd2: rd_mux[PRESCALE_WIDTH-1:0] = prescale_q;
      3'd3: rd_mux[1:0] = {cap_flag, exp_q};
      3'd4: rd_mux = count_q;
`ifdef TIMER_CAPTURE_EN
      3'd5: rd_mux = capture_q;
`endif
      default: rd_mux = '0;
    endcase
    rdata_d = i_rd ? rd_mux : rdata_q;
    irq_d   = irqen_q & (exp_q | cap_flag);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      irqen_q    <= 1'b0;
      reload_q   <= '0;
      prescale_q <= '0;
      exp_q      <= 1'b0;
      count_q    <= '0;
      pscnt_q    <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      irqen_q    <= irqen_d;
      reload_q   <= reload_d;
      prescale_q <= prescale_d;
      exp_q      <= exp_d;
      count_q    <= count_d;
      pscnt_q    <= pscnt_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

`ifdef TIMER_CAPTURE_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cap_meta_q <= 1'b0;
      cap_sync_q <= 1'b0;
      cap_prev_q <= 1'b0;
      cap_q      <= 1'b0;
      capture_q  <= '0;
    end else begin
      cap_meta_q <= i_capture;
      cap_sync_q <= cap_meta_q;
      cap_prev_q <= cap_sync_q;
      cap_q      <= cap_d;
      capture_q  <= capture_d;
    end
  end
`endif

  assign o_rdata = rdata_q;
  assign o_irq   = irq_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: a vector table for reset/one-shot/register
// behaviour, then hand-written sequences for periodic timing, RELOAD change
// mid-count, set-vs-clear collision and asynchronous reset mid-run.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr, rd;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata, count;
  logic        irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.DATA_WIDTH(32), .PRESCALE_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_rd(rd), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata), .o_irq(irq), .o_count(count)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] count;
    logic        irq;
    logic        chk_rd;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic w, input logic r, input logic [2:0] a,
                              input logic [31:0] d, input logic [31:0] c,
                              input logic q, input logic cr, input logic [31:0] rv);
    vec_t v;
    v.wr = w; v.rd = r; v.addr = a; v.wdata = d;
    v.count = c; v.irq = q; v.chk_rd = cr; v.rdata = rv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply inputs for one cycle; return 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [2:0] a,
                      input logic [31:0] d);
    wr = w; rd = r; addr = a; wdata = d;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = 3'd0; wdata = 32'd0;
    #2;
    chk("rst_count", count, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // ---- table: reset reads, one-shot, W1C, read-during-write, restart ----
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 1, 3'(i), 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 3'd1, 3,     0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'd2, 0,     0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'd0, 5,     3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 0,     2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 0,     1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 0,     0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 0,     0, 0, 0, 0));   // expiry edge
    tbl.push_back(mk(0, 1, 3'd3, 0,     0, 1, 1, 1));   // EXP set, irq up
    tbl.push_back(mk(0, 1, 3'd0, 0,     0, 1, 1, 4));   // EN cleared
    tbl.push_back(mk(0, 0, 3'd0, 0,     0, 1, 0, 0));   // DONE holds 0
    tbl.push_back(mk(1, 0, 3'd3, 1,     0, 1, 0, 0));   // W1C EXP
    tbl.push_back(mk(0, 0, 3'd0, 0,     0, 0, 0, 0));   // irq drops
    tbl.push_back(mk(0, 1, 3'd3, 0,     0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3'd4, 0,     0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 3'd6, 32'hffff, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd6, 0,     0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 3'd1, 9,     0, 0, 1, 3));   // old value read
    tbl.push_back(mk(0, 1, 3'd1, 0,     0, 0, 1, 9));
    tbl.push_back(mk(1, 0, 3'd0, 1,     9, 0, 0, 0));   // DONE -> RUN reload
    tbl.push_back(mk(0, 0, 3'd0, 0,     8, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd0, 0,     7, 0, 1, 1));

    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("vec%0d_count", i), count, tbl[i].count);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].irq});
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].rdata);
    end

    // ---- periodic: RELOAD=2, PRESCALE=4, IRQEN ----
    do_reset();
    step(1, 0, 3'd1, 2);
    step(1, 0, 3'd2, 4);
    step(1, 0, 3'd0, 7);
    chk("per_load", count, 32'd2);
    for (int n = 1; n <= 31; n++) begin
      if (n == 20) step(1, 0, 3'd3, 1);
      else         step(0, 0, 3'd0, 0);
      chk($sformatf("per_count%0d", n), count, 32'(2 - ((n / 5) % 3)));
      chk($sformatf("per_irq%0d", n), {31'd0, irq},
          {31'd0, (n >= 16 && n <= 20) || n == 31});
    end
    step(1, 0, 3'd0, 0);                      // EN=0: freeze
    chk("stop_count", count, 32'd2);
    for (int n = 0; n < 8; n++) begin
      step(0, 0, 3'd0, 0);
      chk($sformatf("frozen%0d", n), count, 32'd2);
    end

    // ---- RELOAD change mid-count ----
    begin
      logic [31:0] exp_c [10] = '{4, 3, 2, 1, 0, 1, 0, 1, 0, 1};
      do_reset();
      step(1, 0, 3'd1, 5);
      step(1, 0, 3'd0, 3);
      chk("rl_load", count, 32'd5);
      for (int n = 1; n <= 10; n++) begin
        if (n == 2) step(1, 0, 3'd1, 1);
        else        step(0, 0, 3'd0, 0);
        chk($sformatf("rl_count%0d", n), count, exp_c[n-1]);
      end
    end

    // ---- W1C on the expiry cycle ----
    do_reset();
    step(1, 0, 3'd1, 1);
    step(1, 0, 3'd0, 7);
    step(0, 0, 3'd0, 0);
    chk("col_count", count, 32'd0);
    step(1, 0, 3'd3, 1);                      // expiry edge + clear
    step(0, 1, 3'd3, 0);
    chk("col_exp", rdata, 32'd1);
    chk("col_irq", {31'd0, irq}, 32'd1);

    // ---- async reset mid-run, then restart ----
    do_reset();
    step(1, 0, 3'd1, 9);
    step(1, 0, 3'd2, 7);
    step(1, 0, 3'd0, 5);
    for (int n = 1; n <= 10; n++) begin
      step(0, n == 10, 3'd1, 0);
      chk($sformatf("ar_count%0d", n), count, (n < 8) ? 32'd9 : 32'd8);
    end
    chk("ar_rdata_pre", rdata, 32'd9);
    #3 rst = 1'b1;
    #1;
    chk("ar_count", count, 32'd0);
    chk("ar_irq", {31'd0, irq}, 32'd0);
    chk("ar_rdata", rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step(0, 0, 3'd0, 0);
      chk($sformatf("ar_idle%0d", n), count, 32'd0);
    end
    step(0, 1, 3'd0, 0);
    chk("ar_ctrl", rdata, 32'd0);
    step(1, 0, 3'd1, 6);
    step(1, 0, 3'd2, 7);
    step(1, 0, 3'd0, 1);
    chk("re_load", count, 32'd6);
    for (int n = 1; n <= 8; n++) begin
      if (n == 4) step(1, 0, 3'd0, 1);        // EN=1 again: no restart
      else        step(0, 0, 3'd0, 0);
      chk($sformatf("re_count%0d", n), count, (n < 8) ? 32'd6 : 32'd5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
